nand_page_prog_seq: RTL and testbench
=====================================

Name: nand_page_prog_seq

Overview:
- Sequences one complete small-page NAND program operation on the flash B bus of the NFC copy datapath.
- Operation: pointer command, program setup, 3 address cycles, PAGE_BYTES data bytes, confirm, R/B wait, status read.
- The NFC top FSM supplies the page number and streams page bytes (read from flash A) through a valid/ready handshake.
- The block reports completion and the pass/fail status bit.

Parameters:
- PAGE_BYTES, 512, data bytes per page (counter width = clog2).
- WE_LO, 1, cycles F_WEN held low per write slot (>=1).
- WE_HI, 1, cycles F_WEN held high per write slot (>=1).
- RE_LO, 2, cycles F_REN held low for the status read (>=1).
- TWB, 8, max cycles to wait for F_RB to fall after the confirm command.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin program of page; sampled only in IDLE.
- page  in  9  page number 0..511; latched on start.
- wr_data  in  8  page byte.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  one-cycle pulse; byte consumed this cycle.
- F_IO_OUT  out  8  flash IO drive value.
- F_IO_OE  out  1  1 = drive F_IO bus.
- F_IO_IN  in  8  flash IO sampled value.
- F_CLE  out  1  command latch enable.
- F_ALE  out  1  address latch enable.
- F_WEN  out  1  write enable, active low.
- F_REN  out  1  read enable, active low.
- F_RB  in  1  ready/busy_n from flash.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of operation.
- fail  out  1  status bit0 of last operation; held until next start.

Behaviour:
- Reset (async, any state): state IDLE; F_WEN=1, F_REN=1, F_CLE=0, F_ALE=0, F_IO_OE=0, F_IO_OUT=0; busy=0, done=0, fail=0, wr_ready=0; byte counter 0.
- Write slot: F_IO_OUT, F_CLE, F_ALE and F_IO_OE are stable for the whole slot.
  - F_WEN low for the first WE_LO cycles, then high for WE_HI cycles.
  - The next slot starts on the following cycle, so the flash latches on the F_WEN rising edge with data stable.
- States and transitions:
  - IDLE: start=1 -> latch page, busy=1, fail=0 -> CMD_PTR. start while busy is ignored.
  - CMD_PTR: slot CLE=1, IO=0x00 -> CMD_SETUP.
  - CMD_SETUP: slot CLE=1, IO=0x80 -> ADDR0.
  - ADDR0: slot ALE=1, IO=0x00 (column) -> ADDR1.
  - ADDR1: slot ALE=1, IO=page[7:0] -> ADDR2.
  - ADDR2: slot ALE=1, IO={7'b0,page[8]} -> DATA.
  - DATA: a slot begins only in a cycle with wr_valid=1.
    - That cycle pulses wr_ready and latches wr_data as IO.
    - wr_valid=0 between slots holds F_WEN high; no timeout.
    - After byte PAGE_BYTES-1 completes -> CMD_PROG.
  - CMD_PROG: slot CLE=1, IO=0x10 -> WAIT_BUSY.
  - WAIT_BUSY: F_IO_OE=0.
    - F_RB=0 -> WAIT_READY.
    - TWB cycles elapse without F_RB falling -> WAIT_READY anyway (fast model).
  - WAIT_READY: F_RB=1 -> CMD_STAT.
  - CMD_STAT: slot CLE=1, IO=0x70 -> READ_STAT.
  - READ_STAT: F_IO_OE=0, F_REN low RE_LO cycles.
    - F_IO_IN[0] is sampled into fail on the last low cycle.
    - Then F_REN high for 1 cycle -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- F_CLE/F_ALE are 0 and F_IO_OE=0 in all non-slot cycles. F_CLE and F_ALE are never both high.
- wr_ready is never asserted outside DATA. Exactly PAGE_BYTES wr_ready pulses occur per operation.
- Latency (WE_LO=WE_HI=1, wr_valid always 1, F_RB behaviour ignored):
  - first F_WEN low in the cycle after start;
  - 0x10 slot ends at start + 2*(5+PAGE_BYTES+1) cycles.
- start asserted in the same cycle as done is ignored; start is accepted from the following cycle.

Test Plan:
- Program page 3 with bytes k%256 (wr_valid always high), flash_b model -> model Mem[1536..2047] = 00..FF,00..FF; done once; fail=0; exactly 512 wr_ready pulses.
- page=511 -> address bytes 0x00, 0xFF, 0x01 on successive ALE slots; command sequence observed 0x00, 0x80, then 0x10, 0x70.
- wr_valid toggles 1/0 every 3 cycles -> F_WEN stays high while wr_valid=0; page data identical to the unstalled run; no byte duplicated or dropped.
- Reset asserted mid-DATA at byte 100 -> F_WEN=1, busy=0, wr_ready=0 immediately; a new start for page 4 completes normally.
- Status model returns 0x01 -> fail=1 with the done pulse; it stays 1 until the next start, then clears to 0 in the start cycle.
- F_RB never falls -> WAIT_BUSY exits after TWB=8 cycles; start pulsed while busy -> ignored, page latch unchanged.

Source files
------------

// File: rtl/nand_page_prog_seq.sv
// Small-page NAND program sequencer: cmd 00/80, 3 address cycles, PAGE_BYTES data, 10, R/B wait, 70 status read.
// First F_WEN low the cycle after start; a data slot opens only when wr_valid is high, and F_WEN idles high otherwise.
module nand_page_prog_seq #(
  parameter int PAGE_BYTES = 512,
  parameter int WE_LO      = 1,
  parameter int WE_HI      = 1,
  parameter int RE_LO      = 2,
  parameter int TWB        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] page,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] F_IO_OUT,
  output logic       F_IO_OE,
  input  logic [7:0] F_IO_IN,
  output logic       F_CLE,
  output logic       F_ALE,
  output logic       F_WEN,
  output logic       F_REN,
  input  logic       F_RB,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  localparam int SLOT = WE_LO + WE_HI;
  localparam int M1   = (SLOT > TWB) ? SLOT : TWB;
  localparam int CMAX = (M1 > RE_LO + 1) ? M1 : RE_LO + 1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;

  localparam logic [CW-1:0] WE_LO_C  = CW'(WE_LO);
  localparam logic [CW-1:0] SLOT_END = CW'(SLOT - 1);
  localparam logic [CW-1:0] TWB_END  = CW'(TWB - 1);
  localparam logic [CW-1:0] RE_LO_C  = CW'(RE_LO);
  localparam logic [CW-1:0] RE_LAST  = CW'(RE_LO - 1);
  localparam logic [BW-1:0] BYTE_END = BW'(PAGE_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, CMD_PTR, CMD_SETUP, ADDR0, ADDR1, ADDR2, DATA,
    CMD_PROG, WAIT_BUSY, WAIT_READY, CMD_STAT, READ_STAT, DONE
  } state_t;

  state_t        state, state_nxt, slot_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] byte_cnt, byte_nxt;
  logic [8:0]    page_q;
  logic [7:0]    data_q, slot_io;
  logic          fail_q, slot;

  wire unused_io = &{1'b0, F_IO_IN[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      byte_cnt <= '0;
      page_q   <= '0;
      data_q   <= '0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      byte_cnt <= byte_nxt;
      if (state == IDLE && start) begin
        page_q <= page;
        fail_q <= 1'b0;
      end
      if (wr_ready) data_q <= wr_data;
      if (state == READ_STAT && cnt == RE_LAST) fail_q <= F_IO_IN[0];
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = state;
    cnt_nxt   = cnt;
    byte_nxt  = byte_cnt;
    slot      = 1'b0;
    slot_io   = 8'h00;
    F_IO_OUT  = 8'h00;
    F_IO_OE   = 1'b0;
    F_CLE     = 1'b0;
    F_ALE     = 1'b0;
    F_WEN     = 1'b1;
    F_REN     = 1'b1;
    wr_ready  = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = CMD_PTR;
        cnt_nxt   = '0;
      end
      CMD_PTR:   begin slot = 1'b1; F_CLE = 1'b1; slot_io = 8'h00; slot_nxt = CMD_SETUP; end
      CMD_SETUP: begin slot = 1'b1; F_CLE = 1'b1; slot_io = 8'h80; slot_nxt = ADDR0; end
      ADDR0:     begin slot = 1'b1; F_ALE = 1'b1; slot_io = 8'h00; slot_nxt = ADDR1; end
      ADDR1:     begin slot = 1'b1; F_ALE = 1'b1; slot_io = page_q[7:0]; slot_nxt = ADDR2; end
      ADDR2:     begin slot = 1'b1; F_ALE = 1'b1; slot_io = {7'b0, page_q[8]}; slot_nxt = DATA; end
      // The opening cycle drives wr_data straight through; data_q holds it for the rest of the slot.
      DATA: if (cnt != '0 || wr_valid) begin
        slot     = 1'b1;
        wr_ready = (cnt == '0);
        slot_io  = (cnt == '0) ? wr_data : data_q;
        slot_nxt = (byte_cnt == BYTE_END) ? CMD_PROG : DATA;
      end
      CMD_PROG:  begin slot = 1'b1; F_CLE = 1'b1; slot_io = 8'h10; slot_nxt = WAIT_BUSY; end
      WAIT_BUSY: begin
        if (!F_RB || cnt == TWB_END) begin
          state_nxt = WAIT_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_READY: if (F_RB) state_nxt = CMD_STAT;
      CMD_STAT:  begin slot = 1'b1; F_CLE = 1'b1; slot_io = 8'h70; slot_nxt = READ_STAT; end
      READ_STAT: begin
        F_REN = !(cnt < RE_LO_C);
        if (cnt == RE_LO_C) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (slot) begin
      F_IO_OE  = 1'b1;
      F_IO_OUT = slot_io;
      F_WEN    = !(cnt < WE_LO_C);
      if (cnt == SLOT_END) begin
        cnt_nxt   = '0;
        state_nxt = slot_nxt;
        if (state == DATA) byte_nxt = (byte_cnt == BYTE_END) ? '0 : byte_cnt + BW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign fail = fail_q;

endmodule

// File: tb/tb_nand_page_prog_seq.sv
// Directed bench for nand_page_prog_seq with a behavioural flash B model and byte feeder.
module tb_nand_page_prog_seq;

  logic       clk, rst, start, wr_valid, wr_ready;
  logic [8:0] page;
  logic [7:0] wr_data, F_IO_OUT, stat_val;
  logic       F_IO_OE, F_CLE, F_ALE, F_WEN, F_REN, F_RB, busy, done, fail;

  nand_page_prog_seq dut (
    .clk(clk), .rst(rst), .start(start), .page(page),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .F_IO_OUT(F_IO_OUT), .F_IO_OE(F_IO_OE), .F_IO_IN(stat_val),
    .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(F_RB),
    .busy(busy), .done(done), .fail(fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash model / monitor state
  int   cyc = 0, n_cmd, n_addr, n_dat, n_rdy, n_done, n_both, n_inv, rb_cnt = 0;
  int   t_start, t_wen0, t_prog, t_stat;
  logic fail_at_done, prev_wen, rb_never;
  logic [7:0] cmds [8];
  logic [7:0] addrs [4];
  logic [7:0] dbuf [512];

  // Byte feeder
  int   feed_k = 0, feed_cyc = 0;
  logic feed_en = 1'b0, stall = 1'b0, took;

  initial begin
    forever begin
      @(negedge clk);
      took = wr_ready;
      @(posedge clk);
      #1;
      if (took) feed_k++;
      feed_cyc++;
      wr_data  = feed_k[7:0];
      wr_valid = feed_en && (!stall || ((feed_cyc / 3) % 2 == 0));
    end
  end

  initial begin
    prev_wen = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !busy && !rst) t_start = cyc;
      if (busy && !F_WEN && t_wen0 < 0) t_wen0 = cyc;
      if (wr_ready) n_rdy++;
      if (done) begin n_done++; fail_at_done = fail; end
      if (F_CLE && F_ALE) n_both++;
      if (!F_WEN && !F_CLE && !F_ALE && !(wr_ready && wr_valid)) n_inv++;
      if (F_CLE && !F_WEN && F_IO_OUT == 8'h70 && t_stat < 0) t_stat = cyc;
      if (!prev_wen && F_WEN) begin
        if (F_CLE) begin
          if (n_cmd < 8) cmds[n_cmd] = F_IO_OUT;
          n_cmd++;
          if (F_IO_OUT == 8'h10) begin
            t_prog = cyc;
            if (!rb_never) begin F_RB = 1'b0; rb_cnt = 6; end
          end
        end else if (F_ALE) begin
          if (n_addr < 4) addrs[n_addr] = F_IO_OUT;
          n_addr++;
        end else begin
          if (n_dat < 512) dbuf[n_dat] = F_IO_OUT;
          n_dat++;
        end
      end else if (rb_cnt > 0) begin
        rb_cnt--;
        if (rb_cnt == 0) F_RB = 1'b1;
      end
      prev_wen = F_WEN;
    end
  end

  task automatic start_op(input logic [8:0] pg, input logic [7:0] st, input logic rbn, input logic stl);
    @(posedge clk);
    #2;
    n_cmd = 0; n_addr = 0; n_dat = 0; n_rdy = 0; n_done = 0; n_both = 0; n_inv = 0;
    t_start = -1; t_wen0 = -1; t_prog = -1; t_stat = -1; fail_at_done = 1'b0;
    stat_val = st; rb_never = rbn; stall = stl;
    feed_k = 0; feed_cyc = 0; feed_en = 1'b1;
    page = pg; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    for (n = 0; n < 6000 && n_done == 0; n++) @(negedge clk);
    check({tag, "_done_seen"}, n_done != 0, 1);
    feed_en = 1'b0;
  endtask

  function automatic int data_errs();
    int e = 0;
    for (int i = 0; i < 512; i++) if (dbuf[i] !== 8'(i)) e++;
    return e;
  endfunction

  task automatic check_page(input string tag, input logic [8:0] pg);
    check({tag, "_ndat"}, n_dat, 512);
    check({tag, "_nrdy"}, n_rdy, 512);
    check({tag, "_data"}, data_errs(), 0);
    check({tag, "_base"}, {addrs[2][0], addrs[1]} * 512, pg * 512);
    check({tag, "_inv"}, n_inv, 0);
    check({tag, "_clale"}, n_both, 0);
    check({tag, "_ndone"}, n_done, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; page = '0; wr_data = '0; wr_valid = 1'b0;
    stat_val = 8'h00; F_RB = 1'b1; rb_never = 1'b0;
    for (int i = 0; i < 512; i++) dbuf[i] = 8'hxx;
    #3;
    check("reset_ctl", {F_WEN, F_REN, F_CLE, F_ALE, F_IO_OE, busy, done, fail, wr_ready}, 9'b110000000);
    check("reset_io", F_IO_OUT, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // page 3, continuous data
    start_op(9'd3, 8'h00, 1'b0, 1'b0);
    check("p3_busy", busy, 1);
    wait_done("p3");
    check_page("p3", 9'd3);
    check("p3_base_abs", {addrs[2][0], addrs[1]} * 512, 1536);
    check("p3_first_wen", t_wen0 - t_start, 1);
    check("p3_prog_end", t_prog - t_start, 1036);
    check("p3_fail", fail_at_done, 0);

    // page 511: address bytes and command order
    start_op(9'd511, 8'h00, 1'b0, 1'b0);
    wait_done("p511");
    check("p511_naddr", n_addr, 3);
    check("p511_addr", {addrs[0], addrs[1], addrs[2]}, 24'h00FF01);
    check("p511_ncmd", n_cmd, 4);
    check("p511_cmds", {cmds[0], cmds[1], cmds[2], cmds[3]}, 32'h00801070);

    // stalled feeder
    for (int i = 0; i < 512; i++) dbuf[i] = 8'hxx;
    start_op(9'd3, 8'h00, 1'b0, 1'b1);
    wait_done("stall");
    check_page("stall", 9'd3);

    // reset mid-DATA at byte 100, then page 4
    start_op(9'd8, 8'h00, 1'b0, 1'b0);
    for (n = 0; n < 3000 && n_rdy < 100; n++) @(negedge clk);
    check("rst_reach100", n_rdy >= 100, 1);
    rst = 1'b1;
    #1;
    check("rst_async", {F_WEN, busy, wr_ready}, 3'b100);
    feed_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 512; i++) dbuf[i] = 8'hxx;
    start_op(9'd4, 8'h00, 1'b0, 1'b0);
    wait_done("p4");
    check_page("p4", 9'd4);

    // status fail bit held until next start
    start_op(9'd5, 8'h01, 1'b0, 1'b0);
    wait_done("st1");
    check("st1_fail_done", fail_at_done, 1);
    repeat (10) @(negedge clk);
    check("st1_fail_held", fail, 1);
    start_op(9'd6, 8'h00, 1'b0, 1'b0);
    check("st1_fail_clr", fail, 0);
    wait_done("st0");
    check("st0_fail", fail, 0);

    // F_RB never falls; start pulsed while busy with another page
    start_op(9'd2, 8'h00, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    page = 9'd9; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("twb");
    check("twb_gap", t_stat - t_prog, 10);
    check("twb_addr", {addrs[2], addrs[1]}, 16'h0002);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("twb_no_restart", n, 0);
    check("twb_ndone", n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
